// File: rtl/reg_file_pkg.sv
// Shared widths for the register file, ROB, RS and LSB, plus the read-port
// source selector used by the operand lookups.
package reg_file_pkg;

  localparam int REG_IDX_W     = 5;
  localparam int DEF_ROB_POS_W = 4;
  localparam int DEF_XLEN      = 32;
  localparam int DEF_REG_NUM   = 32;

  typedef enum logic [1:0] {
    RD_ZERO,
    RD_BYPASS,
    RD_STORED
  } rd_src_e;

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational operand lookup: x0 forcing, same-cycle commit bypass,
// otherwise the stored value/busy/tag of the selected register.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int XLEN      = DEF_XLEN,
  parameter int ROB_POS_W = DEF_ROB_POS_W
) (
  input  logic [REG_IDX_W-1:0] idx,
  input  logic [XLEN-1:0]      st_val,
  input  logic                 st_busy,
  input  logic [ROB_POS_W-1:0] st_tag,
  input  logic                 rdy,
  input  logic                 reg_write,
  input  logic [REG_IDX_W-1:0] reg_rd,
  input  logic [XLEN-1:0]      reg_val,
  input  logic [ROB_POS_W-1:0] commit_rob_pos,
  output logic [XLEN-1:0]      val,
  output logic                 busy,
  output logic [ROB_POS_W-1:0] rob_pos
);

  rd_src_e src;

  always_comb begin
    src = RD_STORED;
    if (idx == '0)
      src = RD_ZERO;
    else if (rdy && reg_write && reg_rd == idx && st_busy && st_tag == commit_rob_pos)
      src = RD_BYPASS;
  end

  // rob_pos keeps reporting the stored tag even on a bypass hit.
  always_comb begin
    val     = st_val;
    busy    = st_busy;
    rob_pos = st_tag;
    unique case (src)
      RD_ZERO: begin
        val     = '0;
        busy    = 1'b0;
        rob_pos = '0;
      end
      RD_BYPASS: begin
        val  = reg_val;
        busy = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags; receives ROB
// commits and rollback, and serves two operand lookups with commit bypass.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int XLEN      = DEF_XLEN,
  parameter int REG_NUM   = DEF_REG_NUM,
  parameter int ROB_POS_W = DEF_ROB_POS_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 issue,
  input  logic [REG_IDX_W-1:0] issue_rd,
  input  logic [ROB_POS_W-1:0] issue_rob_pos,
  input  logic                 reg_write,
  input  logic [REG_IDX_W-1:0] reg_rd,
  input  logic [XLEN-1:0]      reg_val,
  input  logic [ROB_POS_W-1:0] commit_rob_pos,
  input  logic [REG_IDX_W-1:0] rs1,
  output logic [XLEN-1:0]      rs1_val,
  output logic                 rs1_busy,
  output logic [ROB_POS_W-1:0] rs1_rob_pos,
  input  logic [REG_IDX_W-1:0] rs2,
  output logic [XLEN-1:0]      rs2_val,
  output logic                 rs2_busy,
  output logic [ROB_POS_W-1:0] rs2_rob_pos
);

  logic [REG_NUM-1:0][XLEN-1:0]      val_q;
  logic [REG_NUM-1:0]                busy_q;
  logic [REG_NUM-1:0][ROB_POS_W-1:0] tag_q;

  logic commit_we;
  logic issue_we;

  assign commit_we = reg_write && reg_rd != '0;
  assign issue_we  = issue && issue_rd != '0;

  // Later assignments override earlier ones: rollback beats issue, and both
  // beat the commit's busy clear, which gives issue-wins on a shared rd.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q  <= '0;
      busy_q <= '0;
      tag_q  <= '0;
    end else if (rdy) begin
      if (commit_we) begin
        val_q[reg_rd] <= reg_val;
        if (busy_q[reg_rd] && tag_q[reg_rd] == commit_rob_pos)
          busy_q[reg_rd] <= 1'b0;
      end
      if (rollback) begin
        busy_q <= '0;
      end else if (issue_we) begin
        busy_q[issue_rd] <= 1'b1;
        tag_q[issue_rd]  <= issue_rob_pos;
      end
    end
  end

  reg_file_read_port #(
    .XLEN      (XLEN),
    .ROB_POS_W (ROB_POS_W)
  ) u_rd1 (
    .idx            (rs1),
    .st_val         (val_q[rs1]),
    .st_busy        (busy_q[rs1]),
    .st_tag         (tag_q[rs1]),
    .rdy            (rdy),
    .reg_write      (reg_write),
    .reg_rd         (reg_rd),
    .reg_val        (reg_val),
    .commit_rob_pos (commit_rob_pos),
    .val            (rs1_val),
    .busy           (rs1_busy),
    .rob_pos        (rs1_rob_pos)
  );

  reg_file_read_port #(
    .XLEN      (XLEN),
    .ROB_POS_W (ROB_POS_W)
  ) u_rd2 (
    .idx            (rs2),
    .st_val         (val_q[rs2]),
    .st_busy        (busy_q[rs2]),
    .st_tag         (tag_q[rs2]),
    .rdy            (rdy),
    .reg_write      (reg_write),
    .reg_rd         (reg_rd),
    .reg_val        (reg_val),
    .commit_rob_pos (commit_rob_pos),
    .val            (rs2_val),
    .busy           (rs2_busy),
    .rob_pos        (rs2_rob_pos)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed plus randomized checks of reg_file against an array-based model.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst_n, rdy, rollback, issue, reg_write;
  logic [4:0]  issue_rd, reg_rd, rs1, rs2;
  logic [3:0]  issue_rob_pos, commit_rob_pos;
  logic [31:0] reg_val;
  logic [31:0] rs1_val, rs2_val;
  logic        rs1_busy, rs2_busy;
  logic [3:0]  rs1_rob_pos, rs2_rob_pos;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  logic [31:0] m_val [32];
  logic        m_busy[32];
  logic [3:0]  m_tag [32];

  always #5 clk = ~clk;

  reg_file #(.XLEN(32), .REG_NUM(32), .ROB_POS_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .rollback(rollback),
    .issue(issue), .issue_rd(issue_rd), .issue_rob_pos(issue_rob_pos),
    .reg_write(reg_write), .reg_rd(reg_rd), .reg_val(reg_val),
    .commit_rob_pos(commit_rob_pos),
    .rs1(rs1), .rs1_val(rs1_val), .rs1_busy(rs1_busy), .rs1_rob_pos(rs1_rob_pos),
    .rs2(rs2), .rs2_val(rs2_val), .rs2_busy(rs2_busy), .rs2_rob_pos(rs2_rob_pos)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", name, obs, exp);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
    end
  endfunction

  // What an operand lookup of register r should show right now.
  task automatic expect_read(input logic [4:0] r, output logic [31:0] v,
                             output logic b, output logic [3:0] p);
    v = m_val[r]; b = m_busy[r]; p = m_tag[r];
    if (r == 0) begin
      v = 0; b = 0; p = 0;
    end else if (rdy && reg_write && reg_rd == r && m_busy[r] && m_tag[r] == commit_rob_pos) begin
      v = reg_val; b = 0;
    end
  endtask

  task automatic check_ports();
    logic [31:0] v; logic b; logic [3:0] p;
    expect_read(rs1, v, b, p);
    chk("rs1_val", rs1_val, v);
    chk("rs1_busy", {31'b0, rs1_busy}, {31'b0, b});
    chk("rs1_rob_pos", {28'b0, rs1_rob_pos}, {28'b0, p});
    expect_read(rs2, v, b, p);
    chk("rs2_val", rs2_val, v);
    chk("rs2_busy", {31'b0, rs2_busy}, {31'b0, b});
    chk("rs2_rob_pos", {28'b0, rs2_rob_pos}, {28'b0, p});
  endtask

  // Clock-edge effect of the current inputs on the architectural state.
  function automatic void model_edge();
    if (!rdy) return;
    if (reg_write && reg_rd != 0) begin
      m_val[reg_rd] = reg_val;
      if (m_busy[reg_rd] && m_tag[reg_rd] == commit_rob_pos) m_busy[reg_rd] = 0;
    end
    if (rollback) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 0;
    end else if (issue && issue_rd != 0) begin
      m_busy[issue_rd] = 1;
      m_tag[issue_rd]  = issue_rob_pos;
    end
  endfunction

  task automatic idle();
    rdy = 1; rollback = 0; issue = 0; issue_rd = 0; issue_rob_pos = 0;
    reg_write = 0; reg_rd = 0; reg_val = 0; commit_rob_pos = 0;
  endtask

  // Inputs are set just after a negedge; check before the posedge, then apply.
  task automatic cycle();
    #1 check_ports();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  initial begin
    idle(); rs1 = 5; rs2 = 0; rst_n = 0;
    model_reset();
    @(negedge clk);
    #1 check_ports();
    chk("reset_rs1_val", rs1_val, 32'h0);
    @(negedge clk);
    rst_n = 1;

    // Issue x3 -> ROB 7, then commit through bypass.
    issue = 1; issue_rd = 3; issue_rob_pos = 7; rs1 = 3;
    cycle();
    idle(); rs1 = 3;
    #1 chk("x3_busy", {31'b0, rs1_busy}, 32'd1);
    chk("x3_pos", {28'b0, rs1_rob_pos}, 32'd7);
    cycle();
    reg_write = 1; reg_rd = 3; reg_val = 32'h1234; commit_rob_pos = 7;
    #1 chk("x3_bypass_val", rs1_val, 32'h1234);
    chk("x3_bypass_busy", {31'b0, rs1_busy}, 32'd0);
    cycle();
    idle(); rs1 = 3;
    #1 chk("x3_stored_val", rs1_val, 32'h1234);
    cycle();

    // Older commit must not release a register owned by a younger producer.
    issue = 1; issue_rd = 4; issue_rob_pos = 2; cycle();
    issue_rob_pos = 5; cycle();
    idle(); reg_write = 1; reg_rd = 4; reg_val = 32'hAA; commit_rob_pos = 2; rs1 = 4;
    cycle();
    idle(); rs1 = 4;
    #1 chk("x4_busy", {31'b0, rs1_busy}, 32'd1);
    chk("x4_pos", {28'b0, rs1_rob_pos}, 32'd5);
    chk("x4_val", rs1_val, 32'hAA);
    cycle();

    // Same-cycle commit and issue to x6: issue wins.
    issue = 1; issue_rd = 6; issue_rob_pos = 1; cycle();
    reg_write = 1; reg_rd = 6; reg_val = 32'hBEEF; commit_rob_pos = 1;
    issue_rob_pos = 9; rs2 = 6;
    cycle();
    idle(); rs2 = 6;
    #1 chk("x6_busy", {31'b0, rs2_busy}, 32'd1);
    chk("x6_pos", {28'b0, rs2_rob_pos}, 32'd9);
    chk("x6_val", rs2_val, 32'hBEEF);
    cycle();

    // Rollback with a commit and an ignored issue in the same cycle.
    issue = 1; issue_rd = 8; issue_rob_pos = 3; cycle();
    issue_rd = 9; issue_rob_pos = 4; cycle();
    idle(); rollback = 1; reg_write = 1; reg_rd = 10; reg_val = 32'h55;
    issue = 1; issue_rd = 11; issue_rob_pos = 6; rs1 = 8; rs2 = 9;
    cycle();
    idle(); rs1 = 10; rs2 = 11;
    #1 chk("rb_x10_val", rs1_val, 32'h55);
    chk("rb_x11_busy", {31'b0, rs2_busy}, 32'd0);
    cycle();
    rs1 = 8; rs2 = 9; cycle();

    // x0 stays zero against commit and issue.
    reg_write = 1; reg_rd = 0; reg_val = 32'hFFFF; issue = 1; issue_rd = 0; issue_rob_pos = 3;
    rs1 = 0; cycle();
    idle(); rs1 = 0;
    #1 chk("x0_val", rs1_val, 32'h0);
    chk("x0_busy", {31'b0, rs1_busy}, 32'd0);
    cycle();

    // rdy low: issue ignored, no bypass even on a matching commit.
    issue = 1; issue_rd = 2; issue_rob_pos = 8; cycle();
    idle(); rdy = 0; issue = 1; issue_rd = 2; issue_rob_pos = 12;
    reg_write = 1; reg_rd = 2; reg_val = 32'h777; commit_rob_pos = 8; rs1 = 2;
    #1 chk("rdy0_busy", {31'b0, rs1_busy}, 32'd1);
    cycle();
    idle(); rs1 = 2;
    #1 chk("rdy0_pos", {28'b0, rs1_rob_pos}, 32'd8);
    chk("rdy0_val", rs1_val, 32'h0);
    cycle();

    // Randomized traffic; commits often target a busy register's own tag.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] pick;
      idle();
      rdy      = ($urandom_range(0, 9) != 0);
      rollback = ($urandom_range(0, 19) == 0);
      issue    = $urandom_range(0, 1);
      issue_rd = 5'($urandom_range(0, 31));
      issue_rob_pos = 4'($urandom);
      reg_write = $urandom_range(0, 1);
      pick = 5'($urandom_range(0, 31));
      reg_rd = pick;
      reg_val = $urandom;
      commit_rob_pos = ($urandom_range(0, 3) != 0) ? m_tag[pick] : 4'($urandom);
      rs1 = ($urandom_range(0, 2) == 0) ? pick : 5'($urandom_range(0, 31));
      rs2 = ($urandom_range(0, 2) == 0) ? issue_rd : 5'($urandom_range(0, 31));
      cycle();
    end

    // Asynchronous reset mid-cycle clears state without a clock edge.
    idle(); rs1 = 3; rs2 = 4;
    #2 rst_n = 0;
    model_reset();
    #1 check_ports();
    chk("async_rst_val", rs1_val, 32'h0);
    @(negedge clk);
    rst_n = 1;
    rs1 = 6; rs2 = 10;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
